// File: rtl/weight_bias_loader_if.sv
// Host stream (s_*) plus the per-neuron weight/bias configuration bus.
// The loader uses the slave modport. The host and neuron side uses the master modport.
interface weight_bias_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        weightValid;
    logic [31:0] weightValue;
    logic        biasValid;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;

    modport master (
        output s_data, s_valid,
        input  s_ready, weightValid, weightValue, biasValid, biasValue,
               config_layer_num, config_neuron_num
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, weightValid, weightValue, biasValid, biasValue,
               config_layer_num, config_neuron_num
    );
endinterface

// File: rtl/weight_bias_loader.sv
// Streams numNeuron x (numWeight weights + 1 bias) host words onto the neuron
// configuration bus. Each neuron receives its weights first and then its bias.
module weight_bias_loader #(
    parameter int layerNo     = 1,
    parameter int numNeuron   = 30,
    parameter int firstNeuron = 0,
    parameter int numWeight   = 784
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    weight_bias_loader_if.slave   bus,
    output logic                  busy,
    output logic                  done
);
    localparam int W_W = $clog2(numWeight + 1);
    localparam int N_W = $clog2(numNeuron + 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, DONE} state_t;

    state_t         state_reg;
    logic [W_W-1:0] w_cnt_reg;
    logic [N_W-1:0] n_cnt_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           beat;

    assign bus.s_ready = (state_reg == LOAD_W) || (state_reg == LOAD_B);
    assign beat        = bus.s_valid && bus.s_ready;
    assign busy        = busy_reg;
    assign done        = done_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg             <= IDLE;
            w_cnt_reg             <= '0;
            n_cnt_reg             <= '0;
            busy_reg              <= 1'b0;
            done_reg              <= 1'b0;
            bus.weightValid       <= 1'b0;
            bus.biasValid         <= 1'b0;
            bus.weightValue       <= '0;
            bus.biasValue         <= '0;
            bus.config_layer_num  <= '0;
            bus.config_neuron_num <= '0;
        end else begin
            // The valids are single-cycle strobes. Only an accepted beat raises one.
            bus.weightValid <= 1'b0;
            bus.biasValid   <= 1'b0;
            done_reg        <= 1'b0;

            // The neuron number uses the counter value from before this beat's increment.
            if (beat) begin
                bus.config_layer_num  <= 32'(layerNo);
                bus.config_neuron_num <= 32'(firstNeuron) + 32'(n_cnt_reg);
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= LOAD_W;
                        w_cnt_reg <= '0;
                        n_cnt_reg <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (beat) begin
                        bus.weightValid <= 1'b1;
                        bus.weightValue <= bus.s_data;
                        if (w_cnt_reg == W_W'(numWeight - 1)) begin
                            w_cnt_reg <= '0;
                            state_reg <= LOAD_B;
                        end else begin
                            w_cnt_reg <= w_cnt_reg + W_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (beat) begin
                        bus.biasValid <= 1'b1;
                        bus.biasValue <= bus.s_data;
                        if (n_cnt_reg == N_W'(numNeuron - 1)) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            n_cnt_reg <= n_cnt_reg + N_W'(1);
                            state_reg <= LOAD_W;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_bias_loader.sv
// Randomized scoreboard bench for weight_bias_loader. Expected beats are derived
// from each beat's index within a run. A negedge monitor checks them against the bus.
module tb_weight_bias_loader;
    localparam int NN    = 2;
    localparam int NW    = 3;
    localparam int LAYER = 1;
    localparam int FIRST = 0;

    typedef struct {
        bit          bias;
        logic [31:0] value;
        int          neuron;
        bit          last;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [31:0] words [8];

    weight_bias_loader_if bus ();

    weight_bias_loader #(
        .layerNo(LAYER), .numNeuron(NN), .firstNeuron(FIRST), .numWeight(NW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_weightValid"}, 32'(bus.weightValid), 32'd0);
        chk({tag, "_biasValid"}, 32'(bus.biasValid), 32'd0);
        chk({tag, "_weightValue"}, bus.weightValue, 32'd0);
        chk({tag, "_biasValue"}, bus.biasValue, 32'd0);
        chk({tag, "_layer"}, bus.config_layer_num, 32'd0);
        chk({tag, "_neuron"}, bus.config_neuron_num, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
    endtask

    // Reference: beat b of a run belongs to neuron b/(NW+1). The last slot of each group is the bias.
    function automatic exp_t model_beat(input int b, input logic [31:0] data, input int acc_cyc);
        exp_t e;
        e.bias   = (b % (NW + 1)) == NW;
        e.value  = data;
        e.neuron = FIRST + b / (NW + 1);
        e.last   = (b == NN * (NW + 1) - 1);
        e.cyc    = acc_cyc;
        return e;
    endfunction

    // Monitor. Any valid must match the oldest expected beat, accepted on the edge just before.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            if (bus.weightValid || bus.biasValid) begin
                chk("valid_exclusive", 32'(bus.weightValid & bus.biasValid), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: weightValid=%0b biasValid=%0b with no beat pending at cycle %0d",
                             bus.weightValid, bus.biasValid, cyc);
                end else begin
                    e = sb_q.pop_front();
                    $display("beat %s neuron=%0d data=0x%08h cycle=%0d",
                             e.bias ? "bias  " : "weight", e.neuron, e.value, cyc);
                    chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                    chk("weightValid", 32'(bus.weightValid), 32'(!e.bias));
                    chk("biasValid", 32'(bus.biasValid), 32'(e.bias));
                    chk(e.bias ? "biasValue" : "weightValue",
                        e.bias ? bus.biasValue : bus.weightValue, e.value);
                    chk("config_neuron_num", bus.config_neuron_num, 32'(e.neuron));
                    chk("config_layer_num", bus.config_layer_num, 32'(LAYER));
                    chk("done_with_last", 32'(done), 32'(e.last));
                end
            end else begin
                chk("done_quiet", 32'(done), 32'd0);
                if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                    e = sb_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_valid: beat for neuron %0d data 0x%08h accepted at cycle %0d never shown",
                             e.neuron, e.value, e.cyc);
                end
            end
        end
    end

    // Called at a negedge. Pulses start, then offers n words.
    // mode 0 offers every cycle, mode 1 offers on alternate cycles and mode 2 offers at random.
    task automatic run_words(input int n, input int mode, input int stall_at, input int start_at,
                             input bit start_on_done, input bit full);
        int b = 0;
        int guard = 0;
        int stall_left = 20;
        bit tog = 1'b0;
        bit offer;
        bit stall_checked = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_after_start", 32'(bus.s_ready), 32'd1);
        while (b < n) begin
            case (mode)
                0:       offer = 1'b1;
                1:       offer = !tog;
                default: offer = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            if (b == stall_at && stall_left > 0) begin
                offer = 1'b0;
                stall_left--;
            end
            bus.s_valid = offer;
            bus.s_data  = offer ? words[b] : $urandom;
            start       = (b == start_at) && offer;
            if (offer && bus.s_ready) begin
                sb_q.push_back(model_beat(b, words[b], cyc + 1));
                b++;
            end
            @(negedge clk);
            if (b == stall_at && stall_left == 0 && !stall_checked) begin
                stall_checked = 1'b1;
                chk("stall_ready_held", 32'(bus.s_ready), 32'd1);
                chk("stall_busy_held", 32'(busy), 32'd1);
            end
            guard++;
            if (guard > 1000) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: only %0d of %0d beats accepted", b, n);
                break;
            end
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
        if (full) begin
            chk("done_at_end", 32'(done), 32'd1);
            start = start_on_done;
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("ready_after_done", 32'(bus.s_ready), 32'd0);
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) words[i] = 32'(i + 1);
        run_words(8, 0, -1, -1, 1'b0, 1'b1);
        run_words(8, 1, -1, -1, 1'b0, 1'b1);
        run_words(8, 0, -1, 1, 1'b0, 1'b1);

        run_words(5, 0, -1, -1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 check_idle("mid_reset");
        sb_q.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) words[i] = 32'(i + 11);
        run_words(8, 0, -1, -1, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) words[i] = $urandom;
        words[3] = 32'hFFFF_FF82;
        words[7] = 32'hFFFF_FF82;
        run_words(8, 2, -1, -1, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) words[i] = $urandom;
        run_words(8, 0, 3, -1, 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) words[i] = $urandom;
            run_words(8, 2, (r == 1) ? 5 : -1, (r == 2) ? 6 : -1, 1'b0, 1'b1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/weight_bias_loader.md
# weight_bias_loader

Sequencer that streams one layer's weight and bias words from a host-side valid/ready source into the neuron array's configuration bus. It drives `weightValid`/`biasValid`, `weightValue`/`biasValue` and `config_layer_num`/`config_neuron_num`: the write side of the per-neuron weight-memory load port. It sits between the host/DMA stream and every neuron of one layer. For each neuron in order it sends `numWeight` weight words, then one bias word, then moves to the next neuron.

## Interface
- `layerNo`, default 1: layer number driven on `config_layer_num` while loading.
- `numNeuron`, default 30: neurons in the layer.
- `firstNeuron`, default 0: `config_neuron_num` value of the first neuron.
- `numWeight`, default 784: weights per neuron; must be ≥ 1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset).
- `start`  in  1  one-cycle pulse; begins a load run when idle.
- `s_data`  in  32  source word (weight or bias, sign-extended by host).
- `s_valid`  in  1  `s_data` valid.
- `s_ready`  out  1  loader accepts a beat this cycle.
- `weightValid`  out  1  `weightValue` is a weight for the addressed neuron.
- `weightValue`  out  32  weight word.
- `biasValid`  out  1  `biasValue` is the bias for the addressed neuron.
- `biasValue`  out  32  bias word.
- `config_layer_num`  out  32  target layer.
- `config_neuron_num`  out  32  target neuron.
- `busy`  out  1  a run is in progress.
- `done`  out  1  one-cycle pulse, run complete.

## Operation
- The FSM has four states: IDLE, LOAD_W, LOAD_B, DONE.
- **IDLE:** `start`=1 → LOAD_W; `w_cnt`=0, `n_cnt`=0. `start` in any other state is ignored.
- **LOAD_W:** each accepted beat (`s_valid & s_ready`) sends one weight and increments `w_cnt`. On the beat with `w_cnt`=`numWeight`-1: `w_cnt`←0 and the state goes to LOAD_B.
- **LOAD_B:** one accepted beat sends the bias.
  - If `n_cnt`=`numNeuron`-1: go to DONE.
  - Otherwise: `n_cnt`+1 and return to LOAD_W.
- **DONE:** lasts one cycle, then returns to IDLE.
- `s_ready` is combinational: 1 in LOAD_W or LOAD_B, 0 in IDLE and DONE. There is no downstream back-pressure; neurons always accept.
- `busy` is 1 in LOAD_W, LOAD_B and DONE. `done` is 1 only in DONE.
- Output registers update on an accepted beat:
  - Weight beat: `weightValid`←1, `biasValid`←0, `weightValue`←`s_data`.
  - Bias beat: `biasValid`←1, `weightValid`←0, `biasValue`←`s_data`.
  - Either beat: `config_layer_num`←`layerNo`, `config_neuron_num`←`firstNeuron`+`n_cnt` (counter value before any increment).
  - No accepted beat: `weightValid`←0 and `biasValid`←0.
- `weightValue`, `biasValue` and the config numbers hold their last value between beats.
- `config_layer_num` and `config_neuron_num` are guaranteed stable in every cycle where a valid is high.
- `weightValid` and `biasValid` are never high together.
- Total beats per run: `numNeuron`×(`numWeight`+1).
- Counter widths: `w_cnt` is $clog2(`numWeight`+1) bits; `n_cnt` is $clog2(`numNeuron`+1) bits. Neither counter wraps, because FSM transitions reset them first.

## Timing
- Reset (`rst`=0, any time, asynchronous):
  - State → IDLE; `w_cnt`=0, `n_cnt`=0.
  - All outputs 0: `weightValid`, `biasValid`, `weightValue`, `biasValue`, `config_layer_num`, `config_neuron_num`, `busy`, `done`; `s_ready` is 0 as a result of IDLE.
- Reset mid-run discards the partial run. After release, the loader waits for a new `start`.
- `start` sampled at edge k → `busy`=1 and `s_ready`=1 from cycle k+1.
- Beat accepted at edge k → the matching valid is high for exactly cycle k+1. Back-to-back beats give a continuous valid.
- Last bias accepted at edge k:
  - Cycle k+1: `biasValid`=1 and `done`=1 together.
  - Cycle k+2: IDLE; `busy`=0.
- LOAD_W→LOAD_B and LOAD_B→LOAD_W cost no bubble. A beat offered in the cycle right after a transition is accepted.
- `s_valid`=0 stalls: counters and state hold, and both valids are 0.
- `start` coincident with `done` is ignored. `start` one cycle later is accepted.

## Test plan
- Use `numNeuron`=2, `numWeight`=3, `layerNo`=1, `firstNeuron`=0.
  - Stimulus: `start`, then 8 continuous beats with `s_data`=1..8.
  - Required: weights 1,2,3 on neuron 0; bias 4 on neuron 0; weights 5,6,7 on neuron 1; bias 8 on neuron 1.
  - Required: `done` and `busy` as specified in Timing; `config_layer_num`=1 throughout.
- Gapped source: `s_valid` toggles 1,0,1,0 across the same 8 words.
  - Required: identical sequence and content; valids are high only in cycles after an accepted beat; `done` fires once.
- `start` pulsed during LOAD_W, in beat 2.
  - Required: no restart; `w_cnt` continues; 8 beats total per run.
- Reset asserted after beat 5.
  - Required: all outputs 0 immediately; `s_ready`=0.
  - Then a new `start` with 8 beats = 11..18: 11 is sent as a weight to neuron 0.
- `s_data`=0xFFFF_FF82 as a bias beat.
  - Required: `biasValue`=0xFFFF_FF82 with `biasValid`=1 for one cycle; `weightValid`=0 in that cycle.
- Source idle: `s_valid`=0 for 20 cycles mid-run.
  - Required: state and counters hold; both valids stay 0; the run resumes correctly.
